// File: rtl/ld_st_if.sv
// ld_st_if: handshake and datapath-control bundle between the ld/ldi/st sequencer and its user/datapath
// Ports: start, ir_op (into the sequencer); busSelect, enable, Control_Signals, MD_Read, ReadRAM,
//        WriteRAM, Gra, Grb, Grc, Rin, Rout, BAout, busy, done, illegal (out of the sequencer).
// master = sequencer side, slave = datapath/controller side.
interface ld_st_if #(
    parameter int BUS_W = 32,
    parameter int CTL_W = 5
);
    logic             start;
    logic [4:0]       ir_op;
    logic [BUS_W-1:0] busSelect;
    logic [BUS_W-1:0] enable;
    logic [CTL_W-1:0] Control_Signals;
    logic             MD_Read;
    logic             ReadRAM;
    logic             WriteRAM;
    logic             Gra;
    logic             Grb;
    logic             Grc;
    logic             Rin;
    logic             Rout;
    logic             BAout;
    logic             busy;
    logic             done;
    logic             illegal;
    modport master (
        input  start, ir_op,
        output busSelect, enable, Control_Signals, MD_Read, ReadRAM, WriteRAM,
               Gra, Grb, Grc, Rin, Rout, BAout, busy, done, illegal
    );
    modport slave (
        output start, ir_op,
        input  busSelect, enable, Control_Signals, MD_Read, ReadRAM, WriteRAM,
               Gra, Grb, Grc, Rin, Rout, BAout, busy, done, illegal
    );
endinterface

// File: rtl/ld_st_sequencer.sv
// ld_st_sequencer: Moore FSM sequencing fetch plus ld/ldi/st execution controls for the 32-bit bus datapath
// Ports: clk (rising edge), clr (async active-high reset), io (ld_st_if.master): start/ir_op in,
//        bus source select, register loads, ALU op, RAM strobes, select-encode controls, busy/done/illegal out.
module ld_st_sequencer #(
    parameter int BUS_W   = 32,
    parameter int CTL_W   = 5,
    parameter int MEM_LAT = 1,
    parameter int OP_LD   = 0,
    parameter int OP_LDI  = 1,
    parameter int OP_ST   = 2
) (
    input logic     clk,
    input logic     clr,
    ld_st_if.master io
);
    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, T7, DONE, ERR} state_t;
    typedef enum logic [1:0] {K_LD, K_LDI, K_ST} kind_t;
    typedef struct packed {
        logic [BUS_W-1:0] bus_select;
        logic [BUS_W-1:0] enable;
        logic [CTL_W-1:0] alu_op;
        logic             md_read;
        logic             read_ram;
        logic             write_ram;
        logic             gra;
        logic             grb;
        logic             rin;
        logic             rout;
        logic             ba_out;
        logic             busy;
        logic             done;
        logic             illegal;
    } ctl_t;
    localparam logic [2:0]       LAT     = 3'(MEM_LAT);
    localparam logic [CTL_W-1:0] ALU_ADD = CTL_W'(1);
    localparam logic [CTL_W-1:0] ALU_INC = CTL_W'(14);
    state_t     state_q, state_d;
    kind_t      kind_q, kind_d;
    logic [2:0] cnt_q, cnt_d;
    ctl_t       ctl_q, ctl_d;
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: state_d = io.start ? T0 : IDLE;
            T0: begin
                state_d = T1;
                cnt_d   = LAT;
            end
            T1: begin
                state_d = cnt_q == 3'd0 ? T2 : T1;
                cnt_d   = cnt_q - 3'd1;
            end
            T2: state_d = T3;
            T3: begin
                kind_d  = io.ir_op == 5'(OP_LD) ? K_LD : io.ir_op == 5'(OP_LDI) ? K_LDI : K_ST;
                state_d = io.ir_op inside {5'(OP_LD), 5'(OP_LDI), 5'(OP_ST)} ? T4 : ERR;
            end
            T4: state_d = T5;
            T5: begin
                state_d = kind_q == K_LDI ? DONE : T6;
                cnt_d   = LAT;
            end
            // ST spends one cycle here; LD waits out the RAM read, then T7 reloads for the ST write
            T6: begin
                state_d = (kind_q == K_ST || cnt_q == 3'd0) ? T7 : T6;
                cnt_d   = (kind_q == K_ST || cnt_q == 3'd0) ? LAT : cnt_q - 3'd1;
            end
            T7: begin
                state_d = (kind_q == K_LD || cnt_q == 3'd0) ? DONE : T7;
                cnt_d   = cnt_q - 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    // Controls are decoded from the next state and registered, so they track state_q glitch-free
    always_comb begin
        ctl_d      = '0;
        ctl_d.busy = state_d != IDLE;
        case (state_d)
            T0: begin
                ctl_d.bus_select[20] = 1'b1;
                ctl_d.enable[25]     = 1'b1;
                ctl_d.enable[18]     = 1'b1;
                ctl_d.alu_op         = ALU_INC;
            end
            T1: begin
                ctl_d.bus_select[19] = 1'b1;
                ctl_d.enable[20]     = state_q != T1;
                ctl_d.enable[21]     = 1'b1;
                ctl_d.md_read        = 1'b1;
                ctl_d.read_ram       = 1'b1;
            end
            T2: begin
                ctl_d.bus_select[21] = 1'b1;
                ctl_d.enable[24]     = 1'b1;
            end
            T3: begin
                ctl_d.grb        = 1'b1;
                ctl_d.ba_out     = 1'b1;
                ctl_d.rout       = 1'b1;
                ctl_d.enable[19] = 1'b1;
            end
            T4: begin
                ctl_d.bus_select[23] = 1'b1;
                ctl_d.alu_op         = ALU_ADD;
                ctl_d.enable[18]     = 1'b1;
            end
            T5: begin
                ctl_d.bus_select[19] = 1'b1;
                ctl_d.gra            = kind_d == K_LDI;
                ctl_d.rin            = kind_d == K_LDI;
                ctl_d.enable[25]     = kind_d != K_LDI;
            end
            T6: begin
                ctl_d.enable[21] = 1'b1;
                ctl_d.md_read    = kind_d == K_LD;
                ctl_d.read_ram   = kind_d == K_LD;
                ctl_d.gra        = kind_d == K_ST;
                ctl_d.rout       = kind_d == K_ST;
            end
            T7: begin
                ctl_d.bus_select[21] = kind_d == K_LD;
                ctl_d.gra            = kind_d == K_LD;
                ctl_d.rin            = kind_d == K_LD;
                ctl_d.write_ram      = kind_d == K_ST;
            end
            DONE: ctl_d.done = 1'b1;
            ERR: ctl_d.illegal = 1'b1;
            default: ;
        endcase
    end
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            kind_q  <= K_LD;
            cnt_q   <= '0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
        end
    end
    assign io.busSelect       = ctl_q.bus_select;
    assign io.enable          = ctl_q.enable;
    assign io.Control_Signals = ctl_q.alu_op;
    assign io.MD_Read         = ctl_q.md_read;
    assign io.ReadRAM         = ctl_q.read_ram;
    assign io.WriteRAM        = ctl_q.write_ram;
    assign io.Gra             = ctl_q.gra;
    assign io.Grb             = ctl_q.grb;
    assign io.Grc             = 1'b0;
    assign io.Rin             = ctl_q.rin;
    assign io.Rout            = ctl_q.rout;
    assign io.BAout           = ctl_q.ba_out;
    assign io.busy            = ctl_q.busy;
    assign io.done            = ctl_q.done;
    assign io.illegal         = ctl_q.illegal;
endmodule
